// File: rtl/fft_pkg.sv
// Shared constants and types for the FFT result serializer.
package fft_pkg;

  localparam int unsigned NPTS  = 32;
  localparam int unsigned OUT_W = 32;
  localparam int unsigned IDX_W = $clog2(NPTS);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPTS - 1);

  typedef logic signed [OUT_W-1:0] bin_t;

  // Number of complete frames held in the ping-pong banks.
  typedef enum logic [1:0] {
    LVL_EMPTY = 2'd0,
    LVL_ONE   = 2'd1,
    LVL_FULL  = 2'd2
  } level_e;

endpackage

// File: rtl/fft_frame_bank.sv
// One frame of bin storage: parallel full-frame load, indexed combinational read.
module fft_frame_bank
  import fft_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [NPTS*OUT_W-1:0] data_flat,
  input  logic [IDX_W-1:0]      rd_addr,
  output bin_t                  rd_data
);

  bin_t mem [NPTS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NPTS; i++) begin
        mem[i] <= '0;
      end
    end else if (load) begin
      for (int unsigned i = 0; i < NPTS; i++) begin
        mem[i] <= data_flat[i*OUT_W +: OUT_W];
      end
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fft_result_serializer.sv
// Captures parallel FFT frames into two banks and streams bins out over valid/ready.
module fft_result_serializer
  import fft_pkg::*;
(
  input  logic                     CLK_10,
  input  logic                     RST,
  input  logic [NPTS*OUT_W-1:0]    X_FLAT,
  input  logic                     IN_VLD,
  output logic signed [OUT_W-1:0]  OUT_DATA,
  output logic [IDX_W-1:0]         OUT_IDX,
  output logic                     OUT_LAST,
  output logic                     OUT_VLD,
  input  logic                     OUT_RDY,
  output logic [1:0]               LEVEL,
  output logic                     OVF
);

  level_e           level, level_nxt;
  logic             wr_bank, rd_bank;
  logic [IDX_W-1:0] idx;
  logic             ovf;

  logic             xfer, rel, free, cap, drop;
  logic             load0, load1;
  bin_t             rd0, rd1;

  always_comb begin
    xfer  = OUT_VLD & OUT_RDY;
    rel   = xfer & (idx == LAST_IDX);
    // A full pair frees a bank in the same cycle its last bin leaves; when full,
    // wr_bank and rd_bank coincide, so the capture lands on the released bank.
    free  = (level != LVL_FULL) | rel;
    cap   = IN_VLD & free;
    drop  = IN_VLD & ~free;
    load0 = cap & ~wr_bank;
    load1 = cap & wr_bank;
  end

  fft_frame_bank u_bank0 (
    .clk       (CLK_10),
    .rst_n     (RST),
    .load      (load0),
    .data_flat (X_FLAT),
    .rd_addr   (idx),
    .rd_data   (rd0)
  );

  fft_frame_bank u_bank1 (
    .clk       (CLK_10),
    .rst_n     (RST),
    .load      (load1),
    .data_flat (X_FLAT),
    .rd_addr   (idx),
    .rd_data   (rd1)
  );

  always_ff @(posedge CLK_10 or negedge RST) begin
    if (!RST) begin
      level <= LVL_EMPTY;
    end else begin
      level <= level_nxt;
    end
  end

  always_comb begin
    level_nxt = level;
    unique case (level)
      LVL_EMPTY: if (cap) level_nxt = LVL_ONE;
      LVL_ONE: begin
        if (cap && !rel)      level_nxt = LVL_FULL;
        else if (rel && !cap) level_nxt = LVL_EMPTY;
      end
      LVL_FULL:  if (rel && !cap) level_nxt = LVL_ONE;
      default:   level_nxt = LVL_EMPTY;
    endcase
  end

  always_ff @(posedge CLK_10 or negedge RST) begin
    if (!RST) begin
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      idx     <= '0;
      ovf     <= 1'b0;
    end else begin
      if (cap) begin
        wr_bank <= ~wr_bank;
      end
      if (rel) begin
        rd_bank <= ~rd_bank;
        idx     <= '0;
      end else if (xfer) begin
        idx <= idx + 1'b1;
      end
      if (drop) begin
        ovf <= 1'b1;
      end
    end
  end

  always_comb begin
    OUT_VLD  = (level != LVL_EMPTY);
    OUT_DATA = rd_bank ? rd1 : rd0;
    OUT_IDX  = idx;
    OUT_LAST = OUT_VLD & (idx == LAST_IDX);
    LEVEL    = level;
    OVF      = ovf;
  end

endmodule

// File: tb/tb_fft_result_serializer.sv
// Directed self-checking bench for fft_result_serializer.
module tb_fft_result_serializer;
  import fft_pkg::*;

  logic                    clk;
  logic                    rst;
  logic [NPTS*OUT_W-1:0]   x_flat;
  logic                    in_vld;
  logic signed [OUT_W-1:0] out_data;
  logic [IDX_W-1:0]        out_idx;
  logic                    out_last;
  logic                    out_vld;
  logic                    out_rdy;
  logic [1:0]              level;
  logic                    ovf;

  int checks = 0;
  int errors = 0;

  fft_result_serializer dut (
    .CLK_10   (clk),
    .RST      (rst),
    .X_FLAT   (x_flat),
    .IN_VLD   (in_vld),
    .OUT_DATA (out_data),
    .OUT_IDX  (out_idx),
    .OUT_LAST (out_last),
    .OUT_VLD  (out_vld),
    .OUT_RDY  (out_rdy),
    .LEVEL    (level),
    .OVF      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // Frame whose bin k equals base + k*step.
  function automatic logic [NPTS*OUT_W-1:0] mk(input int base, input int step);
    logic [NPTS*OUT_W-1:0] f;
    f = '0;
    for (int k = 0; k < int'(NPTS); k++) f[k*OUT_W +: OUT_W] = base + k*step;
    return f;
  endfunction

  task automatic test_reset;
    rst = 1'b0; in_vld = 1'b0; out_rdy = 1'b1; x_flat = mk(123, 1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %0b want 0", out_vld); end
      checks++; if (out_data !== 32'sd0) begin errors++; $display("FAIL reset_data: got %0d want 0", out_data); end
      checks++; if (level !== 2'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", level); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %0b want 0", ovf); end
      in_vld = (c % 2 == 0);
    end
    rst = 1'b1; in_vld = 1'b0;
    @(negedge clk);
    checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL post_reset_vld: got %0b want 0", out_vld); end
    checks++; if (out_idx !== 5'd0) begin errors++; $display("FAIL post_reset_idx: got %0d want 0", out_idx); end
  endtask

  task automatic test_single;
    logic signed [31:0] e;
    x_flat = mk(-5, 1000); in_vld = 1'b1; out_rdy = 1'b1;
    @(negedge clk);
    in_vld = 1'b0;
    checks++; if (level !== 2'd1) begin errors++; $display("FAIL single_level1: got %0d want 1", level); end
    for (int k = 0; k < 32; k++) begin
      e = -5 + k*1000;
      checks++; if (out_vld !== 1'b1) begin errors++; $display("FAIL single_vld k=%0d: got %0b want 1", k, out_vld); end
      checks++; if (out_idx !== 5'(k)) begin errors++; $display("FAIL single_idx: got %0d want %0d", out_idx, k); end
      checks++; if (out_data !== e) begin errors++; $display("FAIL single_data k=%0d: got %0d want %0d", k, out_data, e); end
      checks++; if (out_last !== (k == 31)) begin errors++; $display("FAIL single_last k=%0d: got %0b want %0b", k, out_last, (k == 31)); end
      @(negedge clk);
    end
    checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL single_end_vld: got %0b want 0", out_vld); end
    checks++; if (level !== 2'd0) begin errors++; $display("FAIL single_end_level: got %0d want 0", level); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL single_end_last: got %0b want 0", out_last); end
  endtask

  task automatic test_backpressure;
    logic [3:0] pat;
    logic signed [31:0] e;
    int exp_idx, xfers, c;
    pat = 4'b1001;
    x_flat = mk(100, -37); in_vld = 1'b1; out_rdy = 1'b0;
    @(negedge clk);
    in_vld = 1'b0; exp_idx = 0; xfers = 0; c = 0;
    while (xfers < 32 && c < 200) begin
      e = 100 - 37*exp_idx;
      checks++; if (out_vld !== 1'b1) begin errors++; $display("FAIL bp_vld c=%0d: got %0b want 1", c, out_vld); end
      checks++; if (out_idx !== 5'(exp_idx)) begin errors++; $display("FAIL bp_idx c=%0d: got %0d want %0d", c, out_idx, exp_idx); end
      checks++; if (out_data !== e) begin errors++; $display("FAIL bp_data c=%0d: got %0d want %0d", c, out_data, e); end
      out_rdy = pat[c % 4];
      if (out_rdy) begin exp_idx++; xfers++; end
      c++;
      @(negedge clk);
    end
    checks++; if (xfers !== 32) begin errors++; $display("FAIL bp_xfers: got %0d want 32", xfers); end
    checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL bp_end_vld: got %0b want 0", out_vld); end
    out_rdy = 1'b1;
  endtask

  task automatic test_back_to_back;
    logic signed [31:0] e;
    int k;
    x_flat = mk(32'h7FFFFFFF, 0); in_vld = 1'b1; out_rdy = 1'b1;
    for (int c = 1; c <= 64; c++) begin
      @(negedge clk);
      k = (c - 1) % 32;
      e = (c <= 32) ? 32'sh7FFFFFFF : 32'sh80000000;
      checks++; if (out_vld !== 1'b1) begin errors++; $display("FAIL b2b_vld c=%0d: got %0b want 1", c, out_vld); end
      checks++; if (out_idx !== 5'(k)) begin errors++; $display("FAIL b2b_idx c=%0d: got %0d want %0d", c, out_idx, k); end
      checks++; if (out_data !== e) begin errors++; $display("FAIL b2b_data c=%0d: got %h want %h", c, out_data, e); end
      checks++; if (out_last !== (k == 31)) begin errors++; $display("FAIL b2b_last c=%0d: got %0b want %0b", c, out_last, (k == 31)); end
      if (c >= 11 && c <= 32) begin
        checks++; if (level !== 2'd2) begin errors++; $display("FAIL b2b_level c=%0d: got %0d want 2", c, level); end
      end
      if (c == 1) in_vld = 1'b0;
      if (c == 10) begin x_flat = mk(32'h80000000, 0); in_vld = 1'b1; end
      if (c == 11) in_vld = 1'b0;
    end
    @(negedge clk);
    checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL b2b_end_vld: got %0b want 0", out_vld); end
  endtask

  task automatic test_overflow;
    logic signed [31:0] e;
    out_rdy = 1'b0;
    @(negedge clk); x_flat = mk(4096, 1); in_vld = 1'b1;
    @(negedge clk); x_flat = mk(8192, 1);
    @(negedge clk); x_flat = mk(12288, 1);
    @(negedge clk); in_vld = 1'b0;
    checks++; if (level !== 2'd2) begin errors++; $display("FAIL ovf_level: got %0d want 2", level); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %0b want 1", ovf); end
    out_rdy = 1'b1;
    for (int c = 0; c < 64; c++) begin
      e = ((c < 32) ? 4096 : 8192) + (c % 32);
      checks++; if (out_vld !== 1'b1) begin errors++; $display("FAIL ovf_vld c=%0d: got %0b want 1", c, out_vld); end
      checks++; if (out_idx !== 5'(c % 32)) begin errors++; $display("FAIL ovf_idx c=%0d: got %0d want %0d", c, out_idx, c % 32); end
      checks++; if (out_data !== e) begin errors++; $display("FAIL ovf_data c=%0d: got %0d want %0d", c, out_data, e); end
      @(negedge clk);
    end
    checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL ovf_end_vld: got %0b want 0", out_vld); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %0b want 1", ovf); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_cleared: got %0b want 0", ovf); end
    rst = 1'b1;
  endtask

  task automatic test_edge_release;
    int base [3];
    logic signed [31:0] e;
    int k, f;
    base[0] = -1000; base[1] = 50000; base[2] = -7777;
    out_rdy = 1'b1;
    @(negedge clk); x_flat = mk(base[0], 3); in_vld = 1'b1;
    for (int c = 1; c <= 96; c++) begin
      @(negedge clk);
      k = (c - 1) % 32; f = (c - 1) / 32;
      e = base[f] + 3*k;
      checks++; if (out_vld !== 1'b1) begin errors++; $display("FAIL edge_vld c=%0d: got %0b want 1", c, out_vld); end
      checks++; if (out_idx !== 5'(k)) begin errors++; $display("FAIL edge_idx c=%0d: got %0d want %0d", c, out_idx, k); end
      checks++; if (out_data !== e) begin errors++; $display("FAIL edge_data c=%0d: got %0d want %0d", c, out_data, e); end
      if (c == 32 || c == 33) begin
        checks++; if (level !== 2'd2) begin errors++; $display("FAIL edge_level c=%0d: got %0d want 2", c, level); end
      end
      if (c == 65) begin
        checks++; if (level !== 2'd1) begin errors++; $display("FAIL edge_level c=%0d: got %0d want 1", c, level); end
      end
      if (c == 1) x_flat = mk(base[1], 3);
      if (c == 2) in_vld = 1'b0;
      if (c == 32) begin x_flat = mk(base[2], 3); in_vld = 1'b1; end
      if (c == 33) in_vld = 1'b0;
    end
    @(negedge clk);
    checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL edge_end_vld: got %0b want 0", out_vld); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL edge_ovf: got %0b want 0", ovf); end
  endtask

  task automatic test_reset_midframe;
    out_rdy = 1'b1;
    @(negedge clk); x_flat = mk(777, 11); in_vld = 1'b1;
    @(negedge clk); in_vld = 1'b0;
    repeat (12) @(negedge clk);
    checks++; if (out_idx !== 5'd12) begin errors++; $display("FAIL mid_pre_idx: got %0d want 12", out_idx); end
    rst = 1'b0;
    #1;
    checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL mid_vld: got %0b want 0", out_vld); end
    checks++; if (out_data !== 32'sd0) begin errors++; $display("FAIL mid_data: got %0d want 0", out_data); end
    checks++; if (out_idx !== 5'd0) begin errors++; $display("FAIL mid_idx: got %0d want 0", out_idx); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL mid_last: got %0b want 0", out_last); end
    checks++; if (level !== 2'd0) begin errors++; $display("FAIL mid_level: got %0d want 0", level); end
    @(negedge clk);
    rst = 1'b1; x_flat = mk(-300, -7); in_vld = 1'b1;
    @(negedge clk); in_vld = 1'b0;
    checks++; if (out_vld !== 1'b1) begin errors++; $display("FAIL mid_new_vld: got %0b want 1", out_vld); end
    checks++; if (out_idx !== 5'd0) begin errors++; $display("FAIL mid_new_idx0: got %0d want 0", out_idx); end
    checks++; if (out_data !== -32'sd300) begin errors++; $display("FAIL mid_new_data0: got %0d want -300", out_data); end
    @(negedge clk);
    checks++; if (out_idx !== 5'd1) begin errors++; $display("FAIL mid_new_idx1: got %0d want 1", out_idx); end
    checks++; if (out_data !== -32'sd307) begin errors++; $display("FAIL mid_new_data1: got %0d want -307", out_data); end
  endtask

  initial begin
    rst = 1'b0; in_vld = 1'b0; out_rdy = 1'b0; x_flat = '0;
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_overflow();
    test_edge_release();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
